// File: rtl/cfu_mac_pkg.sv
// Shared opcodes, FSM states and constants for the int8 MAC/requant CFU.
package cfu_mac_pkg;

  localparam int unsigned ACC_W  = 32;
  localparam int unsigned PROD_W = 18;

  localparam logic [31:0] INT32_MIN = 32'h8000_0000;
  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;

  localparam logic [6:0] OP_CLEAR      = 7'd0;
  localparam logic [6:0] OP_MAC        = 7'd1;
  localparam logic [6:0] OP_SET_QUANT  = 7'd2;
  localparam logic [6:0] OP_SET_OFFSET = 7'd3;
  localparam logic [6:0] OP_READ_ACC   = 7'd4;
  localparam logic [6:0] OP_REQUANT    = 7'd5;
  localparam logic [6:0] OP_ADD_BIAS   = 7'd6;
  localparam logic [6:0] OP_PERF       = 7'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DRAIN,
    S_BIAS,
    S_MUL,
    S_SHIFT,
    S_CLAMP,
    S_RESP
  } state_t;

  // One lane of the dot product: (activation + input offset) * filter, kept to PROD_W bits.
  function automatic logic signed [PROD_W-1:0] lane_mul(input logic [7:0] a,
                                                        input logic [7:0] w,
                                                        input logic [15:0] off);
    logic signed [17:0] s;
    logic signed [35:0] p;
    s = 18'($signed(a)) + 18'($signed(off));
    p = 36'(s) * 36'($signed(w));
    return p[PROD_W-1:0];
  endfunction

endpackage

// File: rtl/cfu_requant_unit.sv
// Requantization datapath: SRDHM multiply, rounding right shift, output offset and clamp.
// Stages are loaded by the controlling FSM; the clamp stage is combinational into the response register.
module cfu_requant_unit
  import cfu_mac_pkg::*;
#(
  parameter int ACT_MIN = -128,
  parameter int ACT_MAX = 127
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mul_en,
  input  logic             shift_en,
  input  logic [ACC_W-1:0] acc,
  input  logic [31:0]      quant_mult,
  input  logic [31:0]      quant_shift,
  input  logic [15:0]      out_offset,
  output logic [31:0]      result_c
);

  logic [4:0]         lsh_c, rsh_c;
  logic [31:0]        x_c, mask_c, rem_c, thr_c;
  logic signed [32:0] neg_c, sum_c;
  logic signed [63:0] ab_c, ab_q, t_c, q_c;
  logic signed [31:0] v_q, rd_c;
  logic               sat_q;

  // Positive shift scales the accumulator up before the multiply, negative shift rounds down after.
  always_comb begin
    lsh_c = '0;
    rsh_c = '0;
    neg_c = -33'($signed(quant_shift));
    if (!quant_shift[31] && quant_shift != 32'd0)
      lsh_c = (quant_shift > 32'd31) ? 5'd31 : quant_shift[4:0];
    if (quant_shift[31])
      rsh_c = (neg_c > 33'sd31) ? 5'd31 : neg_c[4:0];
    x_c  = acc << lsh_c;
    ab_c = 64'($signed(x_c)) * 64'($signed(quant_mult));
  end

  // Nudged division by 2^31 truncating toward zero.
  always_comb begin
    t_c = ab_q + (ab_q[63] ? (64'sd1 - 64'sd1073741824) : 64'sd1073741824);
    q_c = t_c[63] ? ((t_c + 64'sd2147483647) >>> 31) : (t_c >>> 31);
  end

  always_comb begin
    mask_c = (32'd1 << rsh_c) - 32'd1;
    rem_c  = v_q & mask_c;
    thr_c  = (mask_c >> 1) + {31'd0, v_q[31]};
    rd_c   = (v_q >>> rsh_c) + $signed({31'd0, (rem_c > thr_c)});
    sum_c  = 33'(rd_c) + 33'($signed(out_offset));
    if (sum_c < 33'(ACT_MIN))      result_c = 32'(ACT_MIN);
    else if (sum_c > 33'(ACT_MAX)) result_c = 32'(ACT_MAX);
    else                           result_c = 32'(sum_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ab_q  <= '0;
      sat_q <= 1'b0;
      v_q   <= '0;
    end else begin
      if (mul_en) begin
        ab_q  <= ab_c;
        sat_q <= (x_c == INT32_MIN) && (quant_mult == INT32_MIN);
      end
      if (shift_en)
        v_q <= sat_q ? $signed(INT32_MAX) : $signed(q_c[31:0]);
    end
  end

endmodule

// File: rtl/cfu_mac_requant.sv
// int8 MAC + requantize CFU: lane buffers, 2-stage dot-product pipe into a 32-bit accumulator,
// and an FSM driving cfu_requant_unit. Define CFU_PERF_CNT_EN to add the pipe-fire counter (op 7).
module cfu_mac_requant
  import cfu_mac_pkg::*;
#(
  parameter int unsigned WORDS            = 4,
  parameter int          INPUT_OFFSET_RST = 128,
  parameter int          ACT_MIN          = -128,
  parameter int          ACT_MAX          = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int unsigned LANES = 4 * WORDS;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  state_t                           state;
  logic [6:0]                       op_q;
  logic [31:0]                      op0_q;
  logic [ACC_W-1:0]                 acc;
  logic [31:0]                      quant_mult, quant_shift;
  logic [15:0]                      out_offset, in_offset;
  logic [WORDS-1:0][31:0]           act_buf, filt_buf;
  logic [IDX_W-1:0]                 word_idx, idx_next_c;
  logic                             fire_q, s1_valid;
  logic [LANES-1:0][PROD_W-1:0]     prod_q, lane_prod_c;
  logic [ACC_W-1:0]                 psum_c [LANES+1];
  logic [31:0]                      requant_c, perf_c;
  logic [6:0]                       opcode;
  logic                             accept, fire_c, pipe_empty;
  logic                             unused_fid;

  assign opcode     = cmd_payload_function_id[9:3];
  assign unused_fid = ^cmd_payload_function_id[2:0];
  assign cmd_ready  = (state == S_IDLE) && !rsp_valid;
  assign accept     = cmd_valid && cmd_ready;
  assign fire_c     = accept && (opcode == OP_MAC) && (word_idx == IDX_LAST);
  assign idx_next_c = (word_idx == IDX_LAST) ? '0 : word_idx + 1'b1;
  assign pipe_empty = !fire_q && !s1_valid;

  // Lane products from the buffers and the adder chain summing the registered products.
  assign psum_c[0] = '0;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_prod_c[i] = lane_mul(act_buf[i/4][8*(i%4) +: 8],
                                     filt_buf[i/4][8*(i%4) +: 8], in_offset);
    assign psum_c[i+1]    = psum_c[i] + ACC_W'($signed(prod_q[i]));
  end

`ifdef CFU_PERF_CNT_EN
  logic [31:0] fire_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fire_cnt <= '0;
    else if (accept && (opcode == OP_PERF) && cmd_payload_inputs_0[0])
      fire_cnt <= '0;
    else if (fire_c)
      fire_cnt <= fire_cnt + 32'd1;
  end
  assign perf_c = fire_cnt;
`else
  assign perf_c = '0;
`endif

  cfu_requant_unit #(
    .ACT_MIN (ACT_MIN),
    .ACT_MAX (ACT_MAX)
  ) u_requant (
    .clk         (clk),
    .reset       (reset),
    .mul_en      (state == S_MUL),
    .shift_en    (state == S_SHIFT),
    .acc         (acc),
    .quant_mult  (quant_mult),
    .quant_shift (quant_shift),
    .out_offset  (out_offset),
    .result_c    (requant_c)
  );

  // Pipe advance first; command handling below overrides acc/pipe where it must.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= S_IDLE;
      op_q                  <= '0;
      op0_q                 <= '0;
      acc                   <= '0;
      quant_mult            <= '0;
      quant_shift           <= '0;
      out_offset            <= '0;
      in_offset             <= 16'(INPUT_OFFSET_RST);
      act_buf               <= '0;
      filt_buf              <= '0;
      word_idx              <= '0;
      fire_q                <= 1'b0;
      s1_valid              <= 1'b0;
      prod_q                <= '0;
      rsp_valid             <= 1'b0;
      rsp_payload_outputs_0 <= '0;
    end else begin
      fire_q   <= 1'b0;
      s1_valid <= fire_q;
      if (fire_q)   prod_q <= lane_prod_c;
      if (s1_valid) acc    <= acc + psum_c[LANES];
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q                  <= opcode;
            op0_q                 <= cmd_payload_inputs_0;
            rsp_payload_outputs_0 <= '0;
            rsp_valid             <= 1'b1;
            case (opcode)
              OP_CLEAR: begin
                acc      <= '0;
                act_buf  <= '0;
                filt_buf <= '0;
                word_idx <= '0;
                fire_q   <= 1'b0;
                s1_valid <= 1'b0;
              end
              OP_MAC: begin
                act_buf[word_idx]     <= cmd_payload_inputs_0;
                filt_buf[word_idx]    <= cmd_payload_inputs_1;
                word_idx              <= idx_next_c;
                fire_q                <= fire_c;
                rsp_payload_outputs_0 <= 32'(idx_next_c);
              end
              OP_SET_QUANT: begin
                quant_mult  <= cmd_payload_inputs_0;
                quant_shift <= cmd_payload_inputs_1;
              end
              OP_SET_OFFSET: begin
                out_offset <= cmd_payload_inputs_0[15:0];
                in_offset  <= cmd_payload_inputs_1[15:0];
              end
              OP_READ_ACC, OP_REQUANT, OP_ADD_BIAS: begin
                rsp_valid <= 1'b0;
                state     <= S_WAIT_DRAIN;
              end
              OP_PERF: rsp_payload_outputs_0 <= perf_c;
              default: ;
            endcase
          end
        end
        S_WAIT_DRAIN: begin
          if (pipe_empty) begin
            case (op_q)
              OP_READ_ACC: begin
                rsp_payload_outputs_0 <= acc;
                rsp_valid             <= 1'b1;
                state                 <= S_RESP;
              end
              OP_ADD_BIAS: state <= S_BIAS;
              OP_REQUANT:  state <= S_MUL;
              default:     state <= S_IDLE;
            endcase
          end
        end
        S_BIAS: begin
          acc                   <= acc + op0_q;
          rsp_payload_outputs_0 <= acc + op0_q;
          rsp_valid             <= 1'b1;
          state                 <= S_RESP;
        end
        S_MUL:   state <= S_SHIFT;
        S_SHIFT: state <= S_CLAMP;
        S_CLAMP: begin
          rsp_payload_outputs_0 <= requant_c;
          rsp_valid             <= 1'b1;
          if (op0_q[0]) acc <= '0;
          state <= S_RESP;
        end
        S_RESP: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
